// File: rtl/vga_window_display.sv
// VGA display stage: sync/timing generator, window-relative frame-buffer read addressing,
// read-latency compensation and 1x/2x replication. Optional macro: VGA_WIN_BORDER_EN.
module vga_window_display #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int WIN_X0   = 20,
  parameter int WIN_Y0   = 40,
  parameter int WIN_W    = 600,
  parameter int WIN_H    = 400,
  parameter int COLOR_W  = 4,
  parameter int GRAY     = 1,
  parameter int SCALE    = 1,
  parameter int RD_LAT   = 1
`ifdef VGA_WIN_BORDER_EN
  , parameter logic [3*COLOR_W-1:0] BORDER_RGB = '1
`endif
) (
  input  logic                   pixel_clk,
  input  logic                   rst,
  input  logic [3*COLOR_W-1:0]   pix_in,
  output logic                   rd_en,
  output logic [9:0]             rd_x,
  output logic [8:0]             rd_y,
  output logic                   frame_start,
  output logic [COLOR_W-1:0]     VGA_R,
  output logic [COLOR_W-1:0]     VGA_G,
  output logic [COLOR_W-1:0]     VGA_B,
  output logic                   VGA_HS,
  output logic                   VGA_VS
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HCW     = $clog2(H_TOTAL + 1);
  localparam int VCW     = $clog2(V_TOTAL + 1);
  localparam int SH      = (SCALE == 2) ? 1 : 0;

  localparam logic [HCW-1:0] H_LAST = HCW'(H_TOTAL - 1);
  localparam logic [VCW-1:0] V_LAST = VCW'(V_TOTAL - 1);
  localparam logic [HCW-1:0] HA_END = HCW'(H_ACTIVE);
  localparam logic [VCW-1:0] VA_END = VCW'(V_ACTIVE);
  localparam logic [HCW-1:0] HS_BEG = HCW'(H_ACTIVE + H_FP);
  localparam logic [HCW-1:0] HS_END = HCW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VCW-1:0] VS_BEG = VCW'(V_ACTIVE + V_FP);
  localparam logic [VCW-1:0] VS_END = VCW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [HCW-1:0] WX_BEG = HCW'(WIN_X0);
  localparam logic [HCW-1:0] WX_END = HCW'(WIN_X0 + WIN_W);
  localparam logic [VCW-1:0] WY_BEG = VCW'(WIN_Y0);
  localparam logic [VCW-1:0] WY_END = VCW'(WIN_Y0 + WIN_H);

`ifdef VGA_WIN_BORDER_EN
  localparam logic [HCW-1:0]       RX_BEG   = HCW'(WIN_X0 - 1);
  localparam logic [HCW-1:0]       RX_END   = HCW'(WIN_X0 + WIN_W);
  localparam logic [VCW-1:0]       RY_BEG   = VCW'(WIN_Y0 - 1);
  localparam logic [VCW-1:0]       RY_END   = VCW'(WIN_Y0 + WIN_H);
  localparam logic [3*COLOR_W-1:0] RING_RGB = BORDER_RGB;
`else
  localparam logic [3*COLOR_W-1:0] RING_RGB = '0;
`endif

  generate
    if (WIN_X0 + WIN_W > H_ACTIVE) begin : g_err_win_x
      $error("window exceeds horizontal active area");
    end
    if (WIN_Y0 + WIN_H > V_ACTIVE) begin : g_err_win_y
      $error("window exceeds vertical active area");
    end
    if (SCALE != 1 && SCALE != 2) begin : g_err_scale
      $error("SCALE must be 1 or 2");
    end
    if (RD_LAT < 0 || RD_LAT > 4) begin : g_err_lat
      $error("RD_LAT must be 0..4");
    end
    if (WIN_W / SCALE > 1024 || WIN_H / SCALE > 512) begin : g_err_addr
      $error("window too large for rd_x/rd_y");
    end
`ifdef VGA_WIN_BORDER_EN
    if (WIN_X0 < 1 || WIN_Y0 < 1) begin : g_err_ring
      $error("border ring needs WIN_X0>=1 and WIN_Y0>=1");
    end
`endif
  endgenerate

  typedef struct packed {
    logic hs;
    logic vs;
    logic win;
    logic act;
    logic ring;
  } pipe_t;

  localparam pipe_t PIPE_RST = '{hs: 1'b1, vs: 1'b1, default: 1'b0};

  logic [HCW-1:0]         hcnt_q, hcnt_d;
  logic [VCW-1:0]         vcnt_q, vcnt_d;
  logic                   rd_en_q, rd_en_d;
  logic [9:0]             rd_x_q, rd_x_d;
  logic [8:0]             rd_y_q, rd_y_d;
  logic                   frame_start_q, frame_start_d;
  pipe_t [RD_LAT:0]       pipe_q, pipe_d;
  logic [3*COLOR_W-1:0]   rgb_q, rgb_d;
  logic                   hs_q, hs_d;
  logic                   vs_q, vs_d;

  logic                   in_win, active, ring;
  logic [HCW-1:0]         x_off;
  logic [VCW-1:0]         y_off;
  logic [3*COLOR_W-1:0]   pix_rgb;
  pipe_t                  tail;

  generate
    if (GRAY != 0) begin : g_gray
      logic unused_pix_hi;
      always_comb begin
        pix_rgb       = {3{pix_in[COLOR_W-1:0]}};
        unused_pix_hi = ^pix_in[3*COLOR_W-1:COLOR_W];
      end
    end else begin : g_rgb
      always_comb pix_rgb = pix_in;
    end
  endgenerate

  always_comb begin : timing_and_stage_a
    hcnt_d = (hcnt_q == H_LAST) ? '0 : hcnt_q + 1'b1;
    vcnt_d = vcnt_q;
    if (hcnt_q == H_LAST) vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;

    in_win = (hcnt_q >= WX_BEG) && (hcnt_q < WX_END) &&
             (vcnt_q >= WY_BEG) && (vcnt_q < WY_END);
    active = (hcnt_q < HA_END) && (vcnt_q < VA_END);
`ifdef VGA_WIN_BORDER_EN
    ring   = active && !in_win &&
             (hcnt_q >= RX_BEG) && (hcnt_q <= RX_END) &&
             (vcnt_q >= RY_BEG) && (vcnt_q <= RY_END);
`else
    ring   = 1'b0;
`endif

    // Replication is a plain right shift of the window offset.
    x_off         = hcnt_q - WX_BEG;
    y_off         = vcnt_q - WY_BEG;
    rd_en_d       = in_win;
    rd_x_d        = in_win ? 10'(x_off >> SH) : '0;
    rd_y_d        = in_win ? 9'(y_off >> SH) : '0;
    frame_start_d = (hcnt_q == '0) && (vcnt_q == '0);

    pipe_d[0] = '{hs:   !((hcnt_q >= HS_BEG) && (hcnt_q < HS_END)),
                  vs:   !((vcnt_q >= VS_BEG) && (vcnt_q < VS_END)),
                  win:  in_win,
                  act:  active,
                  ring: ring};
    for (int unsigned k = 1; k <= RD_LAT; k++) pipe_d[k] = pipe_q[k-1];
  end

  // Sync/window flags leave the delay line in step with the memory data.
  always_comb begin : stage_c
    tail  = pipe_q[RD_LAT];
    hs_d  = tail.hs;
    vs_d  = tail.vs;
    rgb_d = '0;
    if (tail.act) begin
      if (tail.win)       rgb_d = pix_rgb;
      else if (tail.ring) rgb_d = RING_RGB;
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      rd_en_q       <= 1'b0;
      rd_x_q        <= '0;
      rd_y_q        <= '0;
      frame_start_q <= 1'b0;
      pipe_q        <= {(RD_LAT+1){PIPE_RST}};
      rgb_q         <= '0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
    end else begin
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      rd_en_q       <= rd_en_d;
      rd_x_q        <= rd_x_d;
      rd_y_q        <= rd_y_d;
      frame_start_q <= frame_start_d;
      pipe_q        <= pipe_d;
      rgb_q         <= rgb_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
    end
  end

  assign rd_en       = rd_en_q;
  assign rd_x        = rd_x_q;
  assign rd_y        = rd_y_q;
  assign frame_start = frame_start_q;
  assign VGA_R       = rgb_q[3*COLOR_W-1:2*COLOR_W];
  assign VGA_G       = rgb_q[2*COLOR_W-1:COLOR_W];
  assign VGA_B       = rgb_q[COLOR_W-1:0];
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;

endmodule
